// File: rtl/score_keeper.sv
// score_keeper: clamps the running score, tracks the session high score and
// converts both to 2-digit BCD with one shared sequential double-dabble engine.
module score_keeper #(
    parameter int SCORE_W   = 5,
    parameter int MAX_SCORE = 18
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               play,
    input  logic               gameover,
    output logic [7:0]         cur_bcd,
    output logic [7:0]         hi_bcd,
    output logic               new_high,
    output logic               busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

    logic [1:0]         state;
    logic [SCORE_W-1:0] sc, cur_bin, hi_bin, cur_snap, hi_snap, sh;
    logic [7:0]         acc, adj;
    logic [2:0]         cnt;
    logic               sel, play_q, gameover_q;
    logic               req_cur, req_hi, go_rise, play_rise;

    assign sc        = (32'(score) > 32'(MAX_SCORE)) ? MAX_V : score;
    assign req_cur   = cur_bin != cur_snap;
    assign req_hi    = hi_bin != hi_snap;
    assign go_rise   = gameover & ~gameover_q;
    assign play_rise = play & ~play_q;
    assign busy      = state != IDLE;

    // add-3 correction applied to each nibble before the shift
    always_comb begin
        adj = {acc[7:4] >= 4'd5 ? acc[7:4] + 4'd3 : acc[7:4],
               acc[3:0] >= 4'd5 ? acc[3:0] + 4'd3 : acc[3:0]};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_bin    <= '0;
            hi_bin     <= '0;
            new_high   <= 1'b0;
            play_q     <= 1'b0;
            gameover_q <= 1'b0;
        end else begin
            cur_bin    <= sc;
            play_q     <= play;
            gameover_q <= gameover;
            if (go_rise && cur_bin > hi_bin) begin
                hi_bin   <= cur_bin;
                new_high <= 1'b1;
            end
            // a new game always clears the flag, even on a simultaneous gameover rise
            if (play_rise) new_high <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cur_snap <= '0;
            hi_snap  <= '0;
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            sel      <= 1'b0;
            cur_bcd  <= '0;
            hi_bcd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hi) begin
                        sel     <= 1'b1;
                        hi_snap <= hi_bin;
                        sh      <= hi_bin;
                        state   <= LOAD;
                    end else if (req_cur) begin
                        sel      <= 1'b0;
                        cur_snap <= cur_bin;
                        sh       <= cur_bin;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= '0;
                    cnt   <= 3'(SCORE_W);
                    state <= SHIFT;
                end
                SHIFT: begin
                    acc   <= {adj[6:0], sh[SCORE_W-1]};
                    sh    <= sh << 1;
                    cnt   <= cnt - 3'd1;
                    state <= (cnt == 3'd1) ? DONE : SHIFT;
                end
                DONE: begin
                    if (sel) hi_bcd <= acc;
                    else     cur_bcd <= acc;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed vectors with hand-computed expectations for score_keeper.
module tb_score_keeper;
    logic       Clk = 1'b0, Reset = 1'b1, play = 1'b0, gameover = 1'b0;
    logic [4:0] score = 5'd0;
    logic [7:0] cur_bcd, hi_bcd;
    logic       new_high, busy;
    int         vectors = 0, errors = 0;
    int         bc;
    logic [7:0] prev, want;

    score_keeper dut (
        .Clk(Clk), .Reset(Reset), .score(score), .play(play), .gameover(gameover),
        .cur_bcd(cur_bcd), .hi_bcd(hi_bcd), .new_high(new_high), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step(2);
        chk("rst_cur", cur_bcd, 8'h00);
        chk("rst_hi", hi_bcd, 8'h00);
        chk("rst_nh", {7'd0, new_high}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        Reset = 1'b0;
        step(10);
        chk("idle_busy", {7'd0, busy}, 8'd0);

        // reset while the engine is in SHIFT
        score = 5'd13;
        step(4);
        chk("busy_mid", {7'd0, busy}, 8'd1);
        Reset = 1'b1;
        #1;
        chk("amid_cur", cur_bcd, 8'h00);
        chk("amid_hi", hi_bcd, 8'h00);
        chk("amid_nh", {7'd0, new_high}, 8'd0);
        chk("amid_busy", {7'd0, busy}, 8'd0);
        step(2);
        Reset = 1'b0;
        step(8);
        chk("rel_early", cur_bcd, 8'h00);
        step(1);
        chk("rel_cur", cur_bcd, 8'h13);

        // sweep 0..18 with latency and busy length
        prev = 8'h13;
        for (int i = 0; i <= 18; i++) begin
            score = 5'(i);
            want = 8'((i / 10) * 16 + (i % 10));
            bc = 0;
            for (int c = 1; c <= 10; c++) begin
                step(1);
                bc += int'(busy);
                if (c == 8) chk("sweep_hold", cur_bcd, prev);
                if (c == 9) chk("sweep_new", cur_bcd, want);
            end
            chk("busy_len", 8'(bc), 8'd7);
            prev = want;
        end

        // clamp: 31 and 19 both show 18, and no conversion is triggered
        score = 5'd31;
        bc = 0;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            bc += int'(busy);
            chk("clamp31", cur_bcd, 8'h18);
        end
        chk("clamp_busy", 8'(bc), 8'd0);
        score = 5'd19;
        step(10);
        chk("clamp19", cur_bcd, 8'h18);

        // first high score
        score = 5'd12;
        step(10);
        chk("cur12", cur_bcd, 8'h12);
        gameover = 1'b1;
        step(1);
        chk("nh_set", {7'd0, new_high}, 8'd1);
        step(7);
        chk("hi_hold", hi_bcd, 8'h00);
        step(1);
        chk("hi12", hi_bcd, 8'h12);
        gameover = 1'b0;
        play = 1'b1;
        step(1);
        chk("nh_clr", {7'd0, new_high}, 8'd0);
        chk("hi_keep", hi_bcd, 8'h12);
        play = 1'b0;

        // lower and equal scores do not update
        score = 5'd9;
        step(10);
        chk("cur09", cur_bcd, 8'h09);
        gameover = 1'b1;
        step(1);
        chk("nh_low", {7'd0, new_high}, 8'd0);
        step(10);
        chk("hi_low", hi_bcd, 8'h12);
        gameover = 1'b0;
        score = 5'd12;
        step(10);
        gameover = 1'b1;
        step(1);
        chk("nh_eq", {7'd0, new_high}, 8'd0);
        step(10);
        chk("hi_eq", hi_bcd, 8'h12);
        chk("eq_busy", {7'd0, busy}, 8'd0);

        // gameover and play rise together: update applied, flag ends 0
        gameover = 1'b0;
        score = 5'd15;
        step(10);
        gameover = 1'b1;
        play = 1'b1;
        step(1);
        chk("both_nh", {7'd0, new_high}, 8'd0);
        step(8);
        chk("both_hi", hi_bcd, 8'h15);
        gameover = 1'b0;
        play = 1'b0;

        // score change followed by gameover: cur in flight, hi queued behind it
        Reset = 1'b1;
        score = 5'd5;
        step(1);
        Reset = 1'b0;
        step(10);
        chk("s6_cur05", cur_bcd, 8'h05);
        chk("s6_hi00", hi_bcd, 8'h00);
        score = 5'd7;
        step(1);
        gameover = 1'b1;
        step(1);
        chk("s6_nh", {7'd0, new_high}, 8'd1);
        step(6);
        chk("s6_cur_hold", cur_bcd, 8'h05);
        step(1);
        chk("s6_cur07", cur_bcd, 8'h07);
        chk("s6_hi_wait", hi_bcd, 8'h00);
        step(7);
        chk("s6_hi_hold", hi_bcd, 8'h00);
        step(1);
        chk("s6_hi07", hi_bcd, 8'h07);
        chk("s6_cur_keep", cur_bcd, 8'h07);

        // both requests pending in IDLE: hi first, cur one conversion later
        gameover = 1'b0;
        step(2);
        score = 5'd10;
        step(1);
        gameover = 1'b1;
        step(1);
        score = 5'd11;
        step(7);
        chk("pr_cur10", cur_bcd, 8'h10);
        step(7);
        chk("pr_hi_hold", hi_bcd, 8'h07);
        step(1);
        chk("pr_hi10", hi_bcd, 8'h10);
        chk("pr_cur_wait", cur_bcd, 8'h10);
        step(7);
        chk("pr_cur_hold", cur_bcd, 8'h10);
        step(1);
        chk("pr_cur11", cur_bcd, 8'h11);
        gameover = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
